ascon_permutation: RTL and testbench

// Iterative Ascon permutation p^a / p^b, one round per clock. Downstream consumer of the

---
 rtl/ascon_permutation.sv | 138 +++++++++++++
 tb/tb_ascon_permutation.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation.sv
// rtl/ascon_permutation.sv - Iterative Ascon permutation p^a / p^b, one round per clock
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a permutation (taken only while ready=1)
//   rounds     round count 0..15, sampled with start, clamped to MAX_ROUNDS
//   state_in   320-bit input state {x0,x1,x2,x3,x4}, x0 in [319:256]
//   ready      idle and able to accept start
//   busy       rounds are executing
//   done       one-cycle pulse, state_out holds the result
//   state_out  permuted state, stable from done until the next accepted start

module ascon_permutation #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   rounds,
  input  logic [319:0] state_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [319:0] state_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]   fsm;
  logic [63:0]  x0, x1, x2, x3, x4;
  logic [3:0]   idx;
  logic [3:0]   rcnt;
  logic [3:0]   rcnt_req;
  logic [319:0] round_out;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    a0 = s[319:256];
    a1 = s[255:192];
    a2 = s[191:128];
    a3 = s[127:64];
    a4 = s[63:0];
    // Round constant, 8-bit wraparound arithmetic.
    a2[7:0] = a2[7:0] ^ (8'hF0 - 8'd15 * {4'd0, i});
    // Bitsliced 5-bit S-box.
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    // Linear diffusion layer.
    a0 = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
    a1 = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
    a2 = a2 ^ ror64(a2, 1)  ^ ror64(a2, 6);
    a3 = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
    a4 = a4 ^ ror64(a4, 7)  ^ ror64(a4, 41);
    return {a0, a1, a2, a3, a4};
  endfunction

  always_comb begin
    rcnt_req = (rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds;
  end

  always_comb begin
    round_out = ascon_round({x0, x1, x2, x3, x4}, idx);
  end

  assign ready = (fsm == S_IDLE);
  assign busy  = (fsm == S_RUN);
  assign done  = (fsm == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      x4        <= '0;
      idx       <= '0;
      rcnt      <= '0;
      state_out <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start) begin
            {x0, x1, x2, x3, x4} <= state_in;
            rcnt <= rcnt_req;
            // Shorter permutations use the tail of the 12-constant sequence.
            idx  <= 4'd12 - rcnt_req;
            if (rcnt_req == 4'd0) begin
              fsm       <= S_FIN;
              state_out <= state_in;
            end else begin
              fsm <= S_RUN;
            end
          end
        end
        S_RUN: begin
          {x0, x1, x2, x3, x4} <= round_out;
          idx  <= idx + 4'd1;
          rcnt <= rcnt - 4'd1;
          if (rcnt == 4'd1) begin
            fsm       <= S_FIN;
            state_out <= round_out;
          end
        end
        S_FIN: begin
          fsm <= S_IDLE;
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_permutation.sv
// tb/tb_ascon_permutation.sv - Scoreboard bench for ascon_permutation

module tb_ascon_permutation;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   rounds;
  logic [319:0] state_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [319:0] state_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  typedef struct {
    logic [319:0] exp_state;
    int           exp_cyc;
  } exp_t;
  exp_t sb[$];

  ascon_permutation dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .state_in(state_in),
    .ready(ready), .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    int n;
    n = (r > 4'd12) ? 12 : int'(r);
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int rd = 12 - n; rd < 12; rd++) begin
      x[2][7:0] = x[2][7:0] ^ RC[rd];
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[col];
        y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
      end
      x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
      x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
      x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
      x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
      x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on every accepted start, pop and compare on every done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
      end else begin
        chk("flags_exclusive", {319'd0, (ready & busy) | (done & (ready | busy))}, 320'd0);
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 320'd1, 320'd0);
          end else begin
            e = sb.pop_front();
            chk("result", state_out, e.exp_state);
            chk("done_cycle", 320'(cyc), 320'(e.exp_cyc));
          end
        end
        if (start && ready) begin
          e.exp_state = model_perm(state_in, rounds);
          e.exp_cyc   = cyc + 1 + ((rounds > 4'd12) ? 12 : int'(rounds));
          sb.push_back(e);
        end
      end
    end
  end

  task automatic drive_start(input logic [319:0] s, input logic [3:0] r);
    @(negedge clk);
    start = 1'b1; state_in = s; rounds = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found = 0;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {319'd0, found}, 320'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [319:0] iv;
    logic [319:0] rnd;
    logic [319:0] p12;
    logic [319:0] first_res;
    int d_cyc [3];
    bit found;

    iv = {64'h80400C0600000000, 256'd0};
    p12 = model_perm(iv, 4'd12);
    rst = 1'b1; start = 1'b0; rounds = 4'd0; state_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {319'd0, ready}, 320'd1);
    chk("rst_busy", {319'd0, busy}, 320'd0);
    chk("rst_done", {319'd0, done}, 320'd0);
    chk("rst_state_out", state_out, 320'd0);
    rst = 1'b0;

    // p12 from the Ascon-128 IV with zero key and nonce.
    drive_start(iv, 4'd12);
    chk("run_busy", {318'd0, busy, ready}, 320'd2);
    wait_done("p12_done", 30);
    chk("p12_held", state_out, p12);

    // Reset during round 3 aborts the run.
    drive_start(iv, 4'd12);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", {319'd0, ready}, 320'd1);
    chk("abort_busy", {319'd0, busy}, 320'd0);
    chk("abort_done", {319'd0, done}, 320'd0);
    chk("abort_state_out", state_out, 320'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // p6 and p8 from the same input.
    drive_start(iv, 4'd6);
    wait_done("p6_done", 20);
    drive_start(iv, 4'd8);
    wait_done("p8_done", 20);

    // rounds=0 passes state through; rounds=15 clamps to 12.
    for (int i = 0; i < 10; i++) rnd[32*i +: 32] = $urandom;
    drive_start(rnd, 4'd0);
    wait_done("p0_done", 10);
    chk("p0_passthru", state_out, rnd);
    drive_start(iv, 4'd15);
    wait_done("p15_done", 30);
    chk("p15_is_p12", state_out, p12);

    // start during RUN and FIN is ignored.
    drive_start(iv, 4'd8);
    first_res = model_perm(iv, 4'd8);
    start = 1'b1; state_in = rnd; rounds = 4'd3;
    @(negedge clk);
    chk("ignore_run_flags", {318'd0, busy, ready}, 320'd2);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ignore_first_done", {319'd0, found}, 320'd1);
    start = 1'b1; state_in = rnd; rounds = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("ignore_result_held", state_out, first_res);
    chk("ignore_idle_ready", {318'd0, busy, ready}, 320'd1);

    // start tied high: three chained p12 runs.
    start = 1'b1; state_in = iv; rounds = 4'd12;
    for (int r = 0; r < 3; r++) begin
      found = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          found = 1;
          break;
        end
      end
      chk("chain_done", {319'd0, found}, 320'd1);
      d_cyc[r] = cyc;
      state_in = state_out;
      if (r == 2) start = 1'b0;
    end
    chk("chain_period_1", 320'(d_cyc[1] - d_cyc[0]), 320'd14);
    chk("chain_period_2", 320'(d_cyc[2] - d_cyc[1]), 320'd14);
    chk("chain_p12x3", state_out, model_perm(model_perm(p12, 4'd12), 4'd12));
    repeat (20) @(negedge clk);
    chk("chain_sb_empty", 320'(sb.size()), 320'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
